// File: rtl/alu_disp_pkg.sv
// Shared definitions for the ALU result display: opcode codes, active-low
// {g,f,e,d,c,b,a} glyphs and the control FSM state type.
package alu_disp_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_S     = 7'b0010010;
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONV   = 2'd1,
    S_UPDATE = 2'd2
  } state_e;

  function automatic logic [6:0] digitGlyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = SEG_0;
      4'd1:    g = SEG_1;
      4'd2:    g = SEG_2;
      4'd3:    g = SEG_3;
      4'd4:    g = SEG_4;
      4'd5:    g = SEG_5;
      4'd6:    g = SEG_6;
      4'd7:    g = SEG_7;
      4'd8:    g = SEG_8;
      4'd9:    g = SEG_9;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

  function automatic logic [6:0] opGlyph(input logic [1:0] op);
    logic [6:0] g;
    case (op)
      OP_ADD:  g = SEG_A;
      OP_SUB:  g = SEG_S;
      OP_MUL:  g = SEG_P;
      OP_DIV:  g = SEG_D;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: one add-3/shift step per cycle, RES_W steps per
// conversion. `ready` flags the cycle whose edge performs the final step.
module bin2bcd_seq #(
  parameter int RES_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [RES_W-1:0] bin,
  output logic [11:0]      bcd,
  output logic             busy,
  output logic             ready
);

  localparam int SW = 12 + RES_W;

  logic [RES_W-1:0] bin_q;
  logic [RES_W-1:0] binNext;
  logic [11:0]      bcd_q;
  logic [11:0]      bcdAdj;
  logic [11:0]      bcdNext;
  logic [SW-1:0]    shifted;
  logic [3:0]       cnt_q;
  logic             busy_q;

  always_comb begin
    bcdAdj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcdAdj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    shifted = {bcdAdj, bin_q} << 1;
    bcdNext = shifted[SW-1:RES_W];
    binNext = shifted[RES_W-1:0];
  end

  // A start always wins over an iteration in progress so back-to-back
  // conversions can be chained without an idle cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      bin_q  <= bin;
      bcd_q  <= '0;
      cnt_q  <= 4'(RES_W);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      bin_q <= binNext;
      bcd_q <= bcdNext;
      cnt_q <= cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign bcd   = bcd_q;
  assign busy  = busy_q;
  assign ready = busy_q && (cnt_q == 4'd1);

endmodule

// File: rtl/alu_result_display.sv
// Captures an ALU result on the rising edge of `done`, converts it to BCD and
// scans it onto a 4-digit active-low 7-segment display with an opcode glyph.
module alu_result_display
  import alu_disp_pkg::*;
#(
  parameter int RES_W       = 6,
  parameter int REFRESH_DIV = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RES_W-1:0] result,
  input  logic [1:0]       opcode,
  input  logic             done,
  output logic [6:0]       sseg,
  output logic [3:0]       an,
  output logic             busy
);

  localparam int CW = $clog2(REFRESH_DIV);

  state_e           state_q;
  logic             done_q;
  logic             pend_q;
  logic             valid_q;
  logic [RES_W-1:0] pendRes_q;
  logic [1:0]       pendOp_q;
  logic [1:0]       convOp_q;
  logic [1:0]       dispOp_q;
  logic [11:0]      dispBcd_q;

  logic             rise;
  logic             start;
  logic [RES_W-1:0] startRes;
  logic [1:0]       startOp;
  logic [11:0]      cvtBcd;
  logic             cvtBusy;
  logic             cvtReady;

  assign rise = done & ~done_q;

  // A fresh edge in UPDATE is newer than anything pending, so it feeds the
  // converter directly instead of going through the pending slot.
  always_comb begin
    startRes = rise ? result : pendRes_q;
    startOp  = rise ? opcode : pendOp_q;
    case (state_q)
      S_IDLE:   start = rise;
      S_UPDATE: start = rise | pend_q;
      default:  start = 1'b0;
    endcase
  end

  bin2bcd_seq #(.RES_W(RES_W)) uConv (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (startRes),
    .bcd   (cvtBcd),
    .busy  (cvtBusy),
    .ready (cvtReady)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      done_q    <= 1'b0;
      pend_q    <= 1'b0;
      valid_q   <= 1'b0;
      pendRes_q <= '0;
      pendOp_q  <= '0;
      convOp_q  <= '0;
      dispOp_q  <= '0;
      dispBcd_q <= '0;
    end else begin
      done_q <= done;
      if (start) begin
        convOp_q <= startOp;
      end
      case (state_q)
        S_IDLE: begin
          if (rise) begin
            state_q <= S_CONV;
          end
        end
        S_CONV: begin
          if (rise) begin
            pend_q    <= 1'b1;
            pendRes_q <= result;
            pendOp_q  <= opcode;
          end
          if (cvtReady) begin
            state_q <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          dispBcd_q <= cvtBcd;
          dispOp_q  <= convOp_q;
          valid_q   <= 1'b1;
          pend_q    <= 1'b0;
          state_q   <= (rise || pend_q) ? S_CONV : S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The converter is busy from capture through its last step; UPDATE covers
  // the one remaining cycle, so the OR is continuous across chained results.
  assign busy = cvtBusy | (state_q == S_UPDATE);

  logic [CW-1:0] refresh_q;
  logic [1:0]    idx_q;
  logic [1:0]    idxNext;
  logic [3:0]    an_q;
  logic [6:0]    sseg_q;
  logic [6:0]    glyphNext;
  logic          wrap;
  logic [3:0]    hund;
  logic [3:0]    tens;
  logic [3:0]    units;

  assign wrap    = (refresh_q == CW'(REFRESH_DIV - 1));
  assign idxNext = idx_q + 2'd1;
  assign {hund, tens, units} = dispBcd_q;

  always_comb begin
    glyphNext = SEG_DASH;
    if (valid_q) begin
      case (idxNext)
        2'd3:    glyphNext = opGlyph(dispOp_q);
        2'd2:    glyphNext = (hund == 4'd0) ? SEG_BLANK : digitGlyph(hund);
        2'd1:    glyphNext = (hund == 4'd0 && tens == 4'd0) ? SEG_BLANK : digitGlyph(tens);
        default: glyphNext = digitGlyph(units);
      endcase
    end
  end

  // Anode and segments load together from the new index, so they never
  // disagree about which digit is lit.
  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_q <= '0;
      idx_q     <= 2'd0;
      an_q      <= 4'b1110;
      sseg_q    <= SEG_DASH;
    end else if (wrap) begin
      refresh_q <= '0;
      idx_q     <= idxNext;
      an_q      <= ~(4'b0001 << idxNext);
      sseg_q    <= glyphNext;
    end else begin
      refresh_q <= refresh_q + CW'(1);
    end
  end

  assign an   = an_q;
  assign sseg = sseg_q;

endmodule

// File: tb/tb_alu_result_display.sv
// Randomised self-checking bench for alu_result_display against a decimal
// reference model of the expected display contents.
module tb_alu_result_display;

  localparam int RES_W       = 6;
  localparam int REFRESH_DIV = 4;
  localparam int SCAN_CYCLES = 4 * REFRESH_DIV;
  localparam logic [6:0] G_DASH  = 7'b0111111;
  localparam logic [6:0] G_BLANK = 7'b1111111;

  logic             clk = 1'b0;
  logic             reset;
  logic [RES_W-1:0] result;
  logic [1:0]       opcode;
  logic             done;
  logic [6:0]       sseg;
  logic [3:0]       an;
  logic             busy;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  alu_result_display #(.RES_W(RES_W), .REFRESH_DIV(REFRESH_DIV)) dut (
    .clk    (clk),
    .reset  (reset),
    .result (result),
    .opcode (opcode),
    .done   (done),
    .sseg   (sseg),
    .an     (an),
    .busy   (busy)
  );

  function automatic logic [6:0] digitSeg(input int d);
    case (d)
      0:       return 7'b1000000;
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      4:       return 7'b0011001;
      5:       return 7'b0010010;
      6:       return 7'b0000010;
      7:       return 7'b1111000;
      8:       return 7'b0000000;
      9:       return 7'b0010000;
      default: return G_BLANK;
    endcase
  endfunction

  // Expected {digit3, digit2, digit1, digit0} glyphs for a shown value.
  function automatic logic [27:0] modelDisplay(input bit shown, input int value, input logic [1:0] op);
    int h, t, u;
    logic [6:0] opSeg, d2, d1, d0;
    if (!shown) return {G_DASH, G_DASH, G_DASH, G_DASH};
    h = value / 100;
    t = (value / 10) % 10;
    u = value % 10;
    case (op)
      2'b00:   opSeg = 7'b0001000;
      2'b01:   opSeg = 7'b0010010;
      2'b10:   opSeg = 7'b0001100;
      default: opSeg = 7'b0100001;
    endcase
    d2 = (h == 0) ? G_BLANK : digitSeg(h);
    d1 = (h == 0 && t == 0) ? G_BLANK : digitSeg(t);
    d0 = digitSeg(u);
    return {opSeg, d2, d1, d0};
  endfunction

  function automatic int anToDigit(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic scanDisplay(output logic [27:0] seen, output bit anOk);
    int d;
    seen = 'x;
    anOk = 1'b1;
    repeat (SCAN_CYCLES) @(negedge clk);
    for (int c = 0; c < SCAN_CYCLES; c++) begin
      @(negedge clk);
      d = anToDigit(an);
      if (d < 0) anOk = 1'b0;
      else seen[7*d +: 7] = sseg;
    end
  endtask

  task automatic captureAndTime(input logic [RES_W-1:0] r, input logic [1:0] op, output int busyLen);
    @(negedge clk);
    result = r;
    opcode = op;
    done   = 1'b1;
    @(negedge clk);
    done    = 1'b0;
    busyLen = 0;
    while (busy === 1'b1 && busyLen < 100) begin
      busyLen++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [27:0] seen;
    bit anOk;
    reset  = 1'b1;
    done   = 1'b0;
    result = '0;
    opcode = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++;
    if (an !== 4'b1110) $display("[TB] FAIL reset_an: got %b expected 1110", an);
    else passed++;
    checks++;
    if (sseg !== G_DASH) $display("[TB] FAIL reset_sseg: got %b expected %b", sseg, G_DASH);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy);
    else passed++;
    scanDisplay(seen, anOk);
    checks++;
    if (!anOk || seen !== modelDisplay(1'b0, 0, 2'b00))
      $display("[TB] FAIL reset_scan: got %h (an ok %0d) expected %h", seen, anOk, modelDisplay(1'b0, 0, 2'b00));
    else passed++;
  endtask

  task automatic test_conversion(input string name, input int value, input logic [1:0] op);
    int busyLen;
    logic [27:0] seen, expDisp;
    bit anOk;
    captureAndTime(RES_W'(value), op, busyLen);
    checks++;
    if (busyLen != RES_W + 1)
      $display("[TB] FAIL %s_busy_len: value %0d got %0d cycles expected %0d", name, value, busyLen, RES_W + 1);
    else passed++;
    expDisp = modelDisplay(1'b1, value, op);
    scanDisplay(seen, anOk);
    checks++;
    if (!anOk || seen !== expDisp)
      $display("[TB] FAIL %s_display: value %0d op %b got %h expected %h", name, value, op, seen, expDisp);
    else passed++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      test_conversion("random", int'($urandom_range(0, 63)), 2'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_back_to_back();
    logic [27:0] exp63, seen, exp5;
    logic [3:0] prevAn;
    int busyLen, loads, d;
    bit anOk, stillBusy;
    exp63     = modelDisplay(1'b1, 63, 2'b00);
    exp5      = modelDisplay(1'b1, 5, 2'b01);
    busyLen   = 0;
    loads     = 0;
    prevAn    = an;
    stillBusy = 1'b1;
    @(negedge clk);
    result = 6'd63;
    opcode = 2'b00;
    done   = 1'b1;
    for (int k = 0; k < 60 && stillBusy; k++) begin
      @(negedge clk);
      if (busy !== 1'b1) begin
        stillBusy = 1'b0;
      end else begin
        busyLen++;
        if (k == 0) done = 1'b0;
        if (k == 1) begin
          result = 6'd5;
          opcode = 2'b01;
          done   = 1'b1;
        end
        if (k == 2) done = 1'b0;
        if (k == 7) prevAn = an;
        if (k >= 8 && k <= 13 && an !== prevAn) begin
          d = anToDigit(an);
          loads++;
          checks++;
          if (d >= 0 && sseg === exp63[7*d +: 7]) passed++;
          else $display("[TB] FAIL b2b_first_result: an %b got %b expected glyph of 63/A", an, sseg);
          prevAn = an;
        end
      end
    end
    if (done !== 1'b0) done = 1'b0;
    checks++;
    if (busyLen != 2 * (RES_W + 1))
      $display("[TB] FAIL b2b_busy_len: got %0d cycles expected %0d", busyLen, 2 * (RES_W + 1));
    else passed++;
    checks++;
    if (loads == 0) $display("[TB] FAIL b2b_slot_seen: got %0d slot loads expected at least 1", loads);
    else passed++;
    scanDisplay(seen, anOk);
    checks++;
    if (!anOk || seen !== exp5) $display("[TB] FAIL b2b_second_result: got %h expected %h", seen, exp5);
    else passed++;
  endtask

  task automatic test_reset_during_conv();
    logic [27:0] seen;
    bit anOk;
    int busyCount;
    @(negedge clk);
    result = 6'd37;
    opcode = 2'b01;
    done   = 1'b1;
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    result = 6'd12;
    opcode = 2'b10;
    done   = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    done  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0) $display("[TB] FAIL abort_busy: got %b expected 0", busy);
    else passed++;
    checks++;
    if (an !== 4'b1110 || sseg !== G_DASH)
      $display("[TB] FAIL abort_outputs: got an %b sseg %b expected an 1110 sseg %b", an, sseg, G_DASH);
    else passed++;
    busyCount = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy !== 1'b0) busyCount++;
    end
    checks++;
    if (busyCount != 0) $display("[TB] FAIL abort_no_restart: got %0d busy cycles expected 0", busyCount);
    else passed++;
    scanDisplay(seen, anOk);
    checks++;
    if (!anOk || seen !== modelDisplay(1'b0, 0, 2'b00))
      $display("[TB] FAIL abort_dashes: got %h expected %h", seen, modelDisplay(1'b0, 0, 2'b00));
    else passed++;
  endtask

  task automatic test_done_held();
    logic [27:0] seen;
    bit anOk;
    int busyCount;
    int value;
    value = int'($urandom_range(0, 63));
    @(negedge clk);
    result = RES_W'(value);
    opcode = 2'b11;
    done   = 1'b1;
    busyCount = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy === 1'b1) busyCount++;
      if (c == 19) done = 1'b0;
    end
    checks++;
    if (busyCount != RES_W + 1)
      $display("[TB] FAIL held_busy_count: got %0d cycles expected %0d", busyCount, RES_W + 1);
    else passed++;
    scanDisplay(seen, anOk);
    checks++;
    if (!anOk || seen !== modelDisplay(1'b1, value, 2'b11))
      $display("[TB] FAIL held_display: value %0d got %h expected %h", value, seen, modelDisplay(1'b1, value, 2'b11));
    else passed++;
  endtask

  initial begin
    test_reset();
    test_conversion("mul42", 42, 2'b10);
    test_conversion("div0", 0, 2'b11);
    test_random();
    test_back_to_back();
    test_reset_during_conv();
    test_done_held();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
